l2_bus_arbiter: RTL and testbench

- Round-robin, transaction-locked arbiter between the instruction-cache and data-cache back-end native buses and the single native front-end of the AXI L2 cache in `ext_mem`.
- Replaces the purely combinational merge stage.
- Holds a registered grant for the full duration of one request (valid through ready), so a slave stall can never switch masters mid-transaction.
- Rotates priority after every completed transaction to bound starvation.

---
 rtl/l2_arb_pkg.sv | 14 +
 rtl/l2_bus_arbiter_rr_pick.sv | 41 ++++
 rtl/l2_bus_arbiter.sv | 107 ++++++++++
 tb/tb_l2_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the L2 bus arbiter.
package l2_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/l2_bus_arbiter_rr_pick.sv
// Round-robin winner select: rotate requests by ptr, priority-encode,
// then rotate the winning index back.
module rr_pick
  import l2_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = arb_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [N-1:0]  rot;
  logic [IW-1:0] sel;

  always_comb begin
    logic [IW:0] ri;
    logic [IW:0] sum;
    ri  = '0;
    sum = '0;
    rot = '0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      ri = {1'b0, ptr} + (IW+1)'(i);
      if (ri >= N_EXT) ri = ri - N_EXT;
      rot[i] = req[ri[IW-1:0]];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) sel = IW'(i);
    end
    any = |rot;
    sum = {1'b0, sel} + {1'b0, ptr};
    if (sum >= N_EXT) sum = sum - N_EXT;
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Transaction-locked round-robin arbiter merging the cache back-end
// native buses onto the single L2 native front-end.
//
// state    | meaning
// ARB_IDLE | no grant held; pick next requester at or after ptr
// ARB_BUSY | grant locked to grant_q until s_ready completes it
module l2_bus_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_MASTERS-1:0]             m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]      m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]      m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]    m_wstrb,
  output logic [DATA_W-1:0]                m_rdata,
  output logic [N_MASTERS-1:0]             m_ready,
  output logic                             s_valid,
  output logic [ADDR_W-1:0]                s_addr,
  output logic [DATA_W-1:0]                s_wdata,
  output logic [DATA_W/8-1:0]              s_wstrb,
  input  logic [DATA_W-1:0]                s_rdata,
  input  logic                             s_ready,
  output logic                             busy,
  output logic [arb_idx_w(N_MASTERS)-1:0]  grant
);

  localparam int IW = arb_idx_w(N_MASTERS);
  localparam int SW = DATA_W / 8;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  logic [ADDR_W-1:0] addr_a  [N_MASTERS];
  logic [DATA_W-1:0] wdata_a [N_MASTERS];
  logic [SW-1:0]     wstrb_a [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
    assign addr_a[i]  = m_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = m_wdata[i*DATA_W +: DATA_W];
    assign wstrb_a[i] = m_wstrb[i*SW +: SW];
  end

  rr_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_rr_pick (
    .req (m_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // s_ready in BUSY completes even if the master dropped valid early.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    s_valid = 1'b0;
    m_ready = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        s_valid          = m_valid[grant_q];
        m_ready[grant_q] = s_ready;
        if (s_ready) begin
          state_d = ARB_IDLE;
          ptr_d   = (grant_q == IW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Slave-side payload always follows grant_q, even in IDLE.
  assign s_addr  = addr_a[grant_q];
  assign s_wdata = wdata_a[grant_q];
  assign s_wstrb = wstrb_a[grant_q];
  assign m_rdata = s_rdata;
  assign busy    = (state_q == ARB_BUSY);
  assign grant   = grant_q;

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Directed self-checking bench for l2_bus_arbiter (2 masters, 32-bit buses).
module tb_l2_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_valid;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic [1:0]  m_ready;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic        busy;
  logic [0:0]  grant;

  int vec_cnt;
  int err_cnt;
  int rdy0_cnt;
  int rdy1_cnt;

  l2_bus_arbiter #(
    .N_MASTERS (2),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .busy    (busy),
    .grant   (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required done", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst     = 1'b1;
    m_valid = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_rdata = '0;
    s_ready = 1'b0;
    #3;
    chk("rst_busy",    64'(busy),    64'h0);
    chk("rst_s_valid", 64'(s_valid), 64'h0);
    chk("rst_m_ready", 64'(m_ready), 64'h0);
    chk("rst_grant",   64'(grant),   64'h0);
    tick;
    rst = 1'b0;
    tick;

    // Reset mid-transaction with master 1 granted
    m_valid = 2'b10;
    m_addr  = {32'h0000_0B00, 32'h0000_0A00};
    tick;
    chk("t1_grant1",   64'(grant),   64'h1);
    chk("t1_s_valid1", 64'(s_valid), 64'h1);
    s_ready = 1'b1;
    settle;
    chk("t1_m_ready_pre", 64'(m_ready), 64'h2);
    rst = 1'b1;
    settle;
    chk("t1_rst_s_valid", 64'(s_valid), 64'h0);
    chk("t1_rst_m_ready", 64'(m_ready), 64'h0);
    chk("t1_rst_busy",    64'(busy),    64'h0);
    chk("t1_rst_grant",   64'(grant),   64'h0);
    m_valid = 2'b00;
    s_ready = 1'b0;
    settle;
    rst = 1'b0;
    tick;
    m_valid = 2'b11;
    tick;
    chk("t1_ptr0_grant", 64'(grant), 64'h0);
    s_ready = 1'b1;
    settle;
    chk("t1_ptr0_m_ready", 64'(m_ready), 64'h1);
    tick;
    m_valid = 2'b00;
    s_ready = 1'b0;
    tick;

    // Single read by master 0, slave answers three cycles after s_valid
    m_valid = 2'b01;
    m_addr  = {32'h0000_0B00, 32'h0000_1040};
    m_wstrb = 8'h00;
    settle;
    chk("t2_s_valid_t", 64'(s_valid), 64'h0);
    tick;
    chk("t2_s_valid_t1", 64'(s_valid), 64'h1);
    chk("t2_s_addr",     64'(s_addr),  64'h0000_1040);
    chk("t2_s_wstrb",    64'(s_wstrb), 64'h0);
    chk("t2_m_ready_t1", 64'(m_ready), 64'h0);
    tick;
    chk("t2_m_ready_t2", 64'(m_ready), 64'h0);
    tick;
    chk("t2_m_ready_t3", 64'(m_ready), 64'h0);
    tick;
    s_ready = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    settle;
    chk("t2_m_ready_t4", 64'(m_ready), 64'h1);
    chk("t2_m_rdata",    64'(m_rdata), 64'hDEAD_BEEF);
    tick;
    m_valid = 2'b00;
    s_ready = 1'b0;
    settle;
    chk("t2_busy_after",    64'(busy),    64'h0);
    chk("t2_m_ready_after", 64'(m_ready), 64'h0);

    // Contention from reset, single-cycle slave
    rst     = 1'b1;
    m_valid = 2'b11;
    m_addr  = {32'h0000_B000, 32'h0000_A000};
    s_ready = 1'b1;
    settle;
    rst = 1'b0;
    rdy0_cnt = 0;
    rdy1_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (m_ready[0]) rdy0_cnt++;
      if (m_ready[1]) rdy1_cnt++;
      if (c % 2 == 1) begin
        chk($sformatf("t3_s_valid_c%0d", c), 64'(s_valid), 64'h1);
        chk($sformatf("t3_grant_c%0d", c),   64'(grant),   64'(((c - 1) / 2) % 2));
        chk($sformatf("t3_m_ready_c%0d", c), 64'(m_ready), 64'(1 << (((c - 1) / 2) % 2)));
      end else begin
        chk($sformatf("t3_s_valid_c%0d", c), 64'(s_valid), 64'h0);
        chk($sformatf("t3_m_ready_c%0d", c), 64'(m_ready), 64'h0);
      end
    end
    chk("t3_rdy0_cnt", 64'(rdy0_cnt), 64'd2);
    chk("t3_rdy1_cnt", 64'(rdy1_cnt), 64'd2);

    // Stall lock: master 0 held for 20 cycles while master 1 waits
    s_ready = 1'b0;
    tick;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("t4_grant_%0d", c),   64'(grant),   64'h0);
      chk($sformatf("t4_s_addr_%0d", c),  64'(s_addr),  64'h0000_A000);
      chk($sformatf("t4_m_ready_%0d", c), 64'(m_ready), 64'h0);
      tick;
    end
    s_ready = 1'b1;
    settle;
    chk("t4_m_ready_done0", 64'(m_ready), 64'h1);
    tick;
    m_valid = 2'b10;
    s_ready = 1'b0;
    tick;
    chk("t4_grant_next",  64'(grant),   64'h1);
    chk("t4_s_addr_next", 64'(s_addr),  64'h0000_B000);
    chk("t4_s_valid_next", 64'(s_valid), 64'h1);
    s_ready = 1'b1;
    settle;
    chk("t4_m_ready_done1", 64'(m_ready), 64'h2);
    tick;
    m_valid = 2'b00;
    s_ready = 1'b0;
    tick;

    // Write passthrough from master 1
    m_addr  = {32'h0000_2000, 32'h0000_5555};
    m_wdata = {32'h1234_5678, 32'hAAAA_AAAA};
    m_wstrb = {4'b0110, 4'b1111};
    m_valid = 2'b10;
    tick;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t5_s_addr_%0d", c),  64'(s_addr),  64'h0000_2000);
      chk($sformatf("t5_s_wdata_%0d", c), 64'(s_wdata), 64'h1234_5678);
      chk($sformatf("t5_s_wstrb_%0d", c), 64'(s_wstrb), 64'h6);
      chk($sformatf("t5_s_valid_%0d", c), 64'(s_valid), 64'h1);
      tick;
    end
    s_ready = 1'b1;
    settle;
    chk("t5_s_wdata_last", 64'(s_wdata), 64'h1234_5678);
    chk("t5_m_ready",      64'(m_ready), 64'h2);
    tick;
    m_valid = 2'b00;
    s_ready = 1'b0;
    tick;

    // Protocol violation: master 0 drops valid before ready
    m_valid = 2'b01;
    tick;
    chk("t6_s_valid_on", 64'(s_valid), 64'h1);
    m_valid = 2'b00;
    settle;
    chk("t6_s_valid_drop", 64'(s_valid), 64'h0);
    chk("t6_busy_drop",    64'(busy),    64'h1);
    tick;
    chk("t6_busy_hold",  64'(busy),  64'h1);
    chk("t6_grant_hold", 64'(grant), 64'h0);
    s_ready = 1'b1;
    settle;
    chk("t6_m_ready", 64'(m_ready), 64'h1);
    tick;
    s_ready = 1'b0;
    chk("t6_busy_end", 64'(busy), 64'h0);
    m_valid = 2'b11;
    tick;
    chk("t6_resume_grant",   64'(grant),   64'h1);
    chk("t6_resume_s_valid", 64'(s_valid), 64'h1);
    s_ready = 1'b1;
    settle;
    chk("t6_resume_m_ready", 64'(m_ready), 64'h2);
    tick;
    m_valid = 2'b00;
    s_ready = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
